// File: rtl/soc_region_map.sv
// Address-region table with a single-cycle, backpressured lookup pipe and config write port.
// Define SOC_REGION_MAP_LOCK_EN to add per-region write-lock bits that only reset clears.
module soc_region_map #(
    parameter int NumRegions = 12,
    parameter int AddrWidth  = 64,
    parameter int AttrWidth  = 4,
    parameter logic [NumRegions-1:0][AddrWidth-1:0] DefaultBase = '0,
    parameter logic [NumRegions-1:0][AddrWidth-1:0] DefaultLen  = '0,
    parameter logic [NumRegions-1:0][AttrWidth-1:0] DefaultAttr = '0
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic                                                  cfg_valid_i,
    input  logic [((NumRegions > 1) ? $clog2(NumRegions) : 1)-1:0] cfg_idx_i,
    input  logic [AddrWidth-1:0]                                  cfg_base_i,
    input  logic [AddrWidth-1:0]                                  cfg_len_i,
    input  logic [AttrWidth-1:0]                                  cfg_attr_i,
    input  logic                                                  cfg_lock_i,
    output logic                                                  cfg_done_o,
    output logic                                                  cfg_err_o,
    input  logic                                                  req_valid_i,
    output logic                                                  req_ready_o,
    input  logic [AddrWidth-1:0]                                  req_addr_i,
    output logic                                                  resp_valid_o,
    input  logic                                                  resp_ready_i,
    output logic                                                  resp_hit_o,
    output logic [((NumRegions > 1) ? $clog2(NumRegions) : 1)-1:0] resp_idx_o,
    output logic [AttrWidth-1:0]                                  resp_attr_o,
    output logic                                                  resp_multi_o
);

    localparam int IdxWidth = (NumRegions > 1) ? $clog2(NumRegions) : 1;

    logic [NumRegions-1:0]                match;
    logic [NumRegions-1:0]                sel;
    logic [NumRegions-1:0]                locked;
    logic [NumRegions-1:0][AttrWidth-1:0] attr_vec;

    logic                 cfg_err_next;
    logic                 cfg_we;
    logic                 req_accept;
    logic                 hit_next;
    logic                 multi_next;
    logic [IdxWidth-1:0]  idx_next;
    logic [AttrWidth-1:0] attr_next;

    logic                 resp_valid_reg;
    logic                 resp_hit_reg;
    logic                 resp_multi_reg;
    logic [IdxWidth-1:0]  resp_idx_reg;
    logic [AttrWidth-1:0] resp_attr_reg;
    logic                 cfg_done_reg;
    logic                 cfg_err_reg;

    // An index with no select line is out of range; a locked target also rejects the write.
    assign cfg_err_next = !(|sel) || (|(sel & locked));
    assign cfg_we       = cfg_valid_i && !cfg_err_next;

    generate
        for (genvar gi = 0; gi < NumRegions; gi++) begin : gen_region
            logic [AddrWidth-1:0] base_reg;
            logic [AddrWidth-1:0] len_reg;
            logic [AttrWidth-1:0] attr_reg;

            assign sel[gi] = (cfg_idx_i == IdxWidth'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    base_reg <= DefaultBase[gi];
                    len_reg  <= DefaultLen[gi];
                    attr_reg <= DefaultAttr[gi];
                end else if (cfg_we && sel[gi]) begin
                    base_reg <= cfg_base_i;
                    len_reg  <= cfg_len_i;
                    attr_reg <= cfg_attr_i;
                end
            end

            // Upper bound uses one extra bit so a region ending at the top of memory never wraps.
            assign match[gi] = (len_reg != '0) && (req_addr_i >= base_reg) &&
                               ({1'b0, req_addr_i} < ({1'b0, base_reg} + {1'b0, len_reg}));
            assign attr_vec[gi] = attr_reg;

`ifdef SOC_REGION_MAP_LOCK_EN
            logic lock_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    lock_reg <= 1'b0;
                end else if (cfg_we && sel[gi] && cfg_lock_i) begin
                    lock_reg <= 1'b1;
                end
            end

            assign locked[gi] = lock_reg;
`else
            assign locked[gi] = 1'b0;
`endif
        end
    endgenerate

`ifndef SOC_REGION_MAP_LOCK_EN
    logic lock_unused;
    assign lock_unused = cfg_lock_i;
`endif

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        idx_next  = '0;
        attr_next = '0;
        for (int i = NumRegions - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx_next  = IdxWidth'(i);
                attr_next = attr_vec[i];
            end
        end
    end

    assign hit_next   = |match;
    assign multi_next = |(match & (match - NumRegions'(1)));

    assign req_ready_o = !resp_valid_reg || resp_ready_i;
    assign req_accept  = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_reg <= 1'b0;
            resp_hit_reg   <= 1'b0;
            resp_idx_reg   <= '0;
            resp_attr_reg  <= '0;
            resp_multi_reg <= 1'b0;
            cfg_done_reg   <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            if (req_accept) begin
                resp_valid_reg <= 1'b1;
                resp_hit_reg   <= hit_next;
                resp_idx_reg   <= idx_next;
                resp_attr_reg  <= attr_next;
                resp_multi_reg <= multi_next;
            end else if (resp_ready_i) begin
                resp_valid_reg <= 1'b0;
            end
            cfg_done_reg <= cfg_valid_i;
            cfg_err_reg  <= cfg_valid_i && cfg_err_next;
        end
    end

    assign resp_valid_o = resp_valid_reg;
    assign resp_hit_o   = resp_hit_reg;
    assign resp_idx_o   = resp_idx_reg;
    assign resp_attr_o  = resp_attr_reg;
    assign resp_multi_o = resp_multi_reg;
    assign cfg_done_o   = cfg_done_reg;
    assign cfg_err_o    = cfg_err_reg;

endmodule
